// File: rtl/uart_mmio.sv
// Memory-mapped UART at 0xBF00 (DATA) / 0xBF01 (STATUS).
// 8N1 framing with CLKS_PER_BIT clocks per bit; TX and RX run independently.
module uart_mmio #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [15:0] rdata,
    input  logic        rxd,
    output logic        txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0]   ADDR_DATA = 16'hBF00;
    localparam logic [15:0]   ADDR_STAT = 16'hBF01;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic data_wr_s;
    logic data_rd_s;
    logic stat_rd_s;
    logic wdata_unused_s;

    assign data_wr_s      = we & (addr == ADDR_DATA);
    assign data_rd_s      = re & (addr == ADDR_DATA);
    assign stat_rd_s      = re & (addr == ADDR_STAT);
    assign wdata_unused_s = ^wdata[15:8];

    // ------------------------------------------------------------------ TX
    tx_state_t     tx_state_r, tx_state_s;
    logic [CW-1:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]    tx_bit_r, tx_bit_s;
    logic [7:0]    tx_shift_r, tx_shift_s;
    logic          txd_r, txd_s;
    logic          tx_ready_s;

    assign tx_ready_s = (tx_state_r == TX_IDLE);
    assign txd        = txd_r;

    // TX state register; txd is registered so it changes with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            txd_r      <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            txd_r      <= txd_s;
        end
    end

    // TX next-state logic; writes outside IDLE fall through untouched
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        case (tx_state_r)
            TX_IDLE: begin
                if (data_wr_s) begin
                    tx_state_s = TX_START;
                    tx_cnt_s   = '0;
                    tx_bit_s   = 3'd0;
                    tx_shift_s = wdata[7:0];
                end else begin
                    tx_state_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == CNT_FULL) begin
                    tx_state_s = TX_DATA;
                    tx_cnt_s   = '0;
                    tx_bit_s   = 3'd0;
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == CNT_FULL) begin
                    tx_cnt_s = '0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = TX_STOP;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == CNT_FULL) begin
                    tx_state_s = TX_IDLE;
                    tx_cnt_s   = '0;
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_cnt_s   = '0;
            end
        endcase
    end

    // TX output: line level for the state being entered
    always_comb begin
        txd_s = 1'b1;
        case (tx_state_s)
            TX_IDLE:  txd_s = 1'b1;
            TX_START: txd_s = 1'b0;
            TX_DATA:  txd_s = tx_shift_s[0];
            TX_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------ RX
    logic          rx_meta_r, rx_sync_r;
    rx_state_t     rx_state_r, rx_state_s;
    logic [CW-1:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]    rx_bit_r, rx_bit_s;
    logic [7:0]    rx_shift_r, rx_shift_s;
    logic          rx_done_s;
    logic          rx_ferr_s;
    logic [7:0]    rx_buf_r;
    logic          rx_valid_r;
    logic          overrun_r;
    logic          frame_err_r;

    // Two-flop synchronizer for the asynchronous serial input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rxd;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // RX next-state logic; START re-check at half a bit rejects glitches
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_s = RX_START;
                    rx_cnt_s   = '0;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_s = '0;
                    rx_bit_s = 3'd0;
                    if (!rx_sync_r) begin
                        rx_state_s = RX_DATA;
                    end else begin
                        rx_state_s = RX_IDLE;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == CNT_FULL) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == CNT_FULL) begin
                    rx_state_s = RX_IDLE;
                    rx_cnt_s   = '0;
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                rx_cnt_s   = '0;
            end
        endcase
    end

    // RX outputs: stop-bit verdict on the last STOP count
    always_comb begin
        rx_done_s = 1'b0;
        rx_ferr_s = 1'b0;
        case (rx_state_r)
            RX_STOP: begin
                if (rx_cnt_r == CNT_FULL) begin
                    rx_done_s = rx_sync_r;
                    rx_ferr_s = ~rx_sync_r;
                end else begin
                    rx_done_s = 1'b0;
                    rx_ferr_s = 1'b0;
                end
            end
            default: begin
                rx_done_s = 1'b0;
                rx_ferr_s = 1'b0;
            end
        endcase
    end

    // Receive buffer and status flags; a set beats a same-cycle clearing read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_buf_r    <= 8'h00;
            rx_valid_r  <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (rx_done_s) begin
                rx_buf_r <= rx_shift_r;
            end else begin
                rx_buf_r <= rx_buf_r;
            end
            if (rx_done_s) begin
                rx_valid_r <= 1'b1;
            end else if (data_rd_s) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
            if (rx_done_s && rx_valid_r) begin
                overrun_r <= 1'b1;
            end else if (stat_rd_s) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
            if (rx_ferr_s) begin
                frame_err_r <= 1'b1;
            end else if (stat_rd_s) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    // CPU read mux
    always_comb begin
        rdata = 16'h0000;
        if (data_rd_s) begin
            rdata = {8'h00, rx_buf_r};
        end else if (stat_rd_s) begin
            rdata = {12'h000, frame_err_r, overrun_r, rx_valid_r, tx_ready_s};
        end else begin
            rdata = 16'h0000;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: TX frames decoded by a monitor against a
// byte queue, RX bytes/flags checked against a small software model.
module tb_uart_mmio;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic        re;
    logic [15:0] rdata;
    logic        rxd;
    logic        txd;

    int n_cmp = 0;
    int n_err = 0;
    int tx_frames = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] m_buf = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;

    uart_mmio #(.CLKS_PER_BIT(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .rdata (rdata),
        .rxd   (rxd),
        .txd   (txd)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All CPU/serial tasks start and end just after a falling clock edge.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        addr = a;
        re   = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        re   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            idle(16);
        end
        rxd = stop_bit;
        idle(16);
        rxd = 1'b1;
        if (stop_bit) begin
            rx_q.push_back(b);
            if (m_valid) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_buf   = b;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic read_status_check(input string tag);
        logic [15:0] v;
        cpu_read(16'hBF01, v);
        check_eq(tag, v, {12'h000, m_ferr, m_ovr, m_valid, 1'b1});
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic read_data_check(input string tag);
        logic [15:0] v;
        logic [7:0]  exp;
        cpu_read(16'hBF00, v);
        while (rx_q.size() > 1) void'(rx_q.pop_front());
        if (rx_q.size() > 0) exp = rx_q.pop_front();
        else exp = m_buf;
        check_eq(tag, v, {8'h00, exp});
        m_valid = 1'b0;
    endtask

    // TX monitor: samples each bit at its middle and scores the decoded byte
    initial begin : tx_mon
        logic [7:0]  b;
        logic [15:0] exp;
        @(negedge rst);
        forever begin
            @(negedge txd);
            repeat (8) @(posedge clk);
            #1 check_eq("tx_start_bit", {15'h0000, txd}, 16'h0000);
            for (int i = 0; i < 8; i++) begin
                repeat (16) @(posedge clk);
                #1 b[i] = txd;
            end
            repeat (16) @(posedge clk);
            #1 check_eq("tx_stop_bit", {15'h0000, txd}, 16'h0001);
            if (tx_q.size() > 0) exp = {8'h00, tx_q.pop_front()};
            else exp = 16'hFFFF;
            check_eq("tx_byte", {8'h00, b}, exp);
            tx_frames++;
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          busy;
        logic [15:0] st;
        rst   = 1'b1;
        addr  = 16'h0000;
        wdata = 16'h0000;
        we    = 1'b0;
        re    = 1'b0;
        rxd   = 1'b1;
        #15 rst = 1'b0;

        check_eq("rst_txd", {15'h0000, txd}, 16'h0001);
        read_status_check("rst_status");
        cpu_read(16'h1234, st);
        check_eq("unmapped_read", st, 16'h0000);

        // Single TX frame; tx_ready low for exactly the 160-cycle frame
        cpu_write(16'hBF00, 16'h1255);
        tx_q.push_back(8'h55);
        busy = 0;
        for (int i = 0; i < 400; i++) begin
            cpu_read(16'hBF01, st);
            if (st[0]) break;
            busy++;
        end
        check_eq("tx_busy_cycles", 16'(busy), 16'd160);
        idle(4);

        // Write during a frame is dropped; only a new write starts a frame
        cpu_write(16'hBF00, 16'h1255);
        tx_q.push_back(8'h55);
        idle(20);
        cpu_write(16'hBF00, 16'h00AA);
        idle(200);
        check_eq("tx_frames_after_drop", 16'(tx_frames), 16'd2);
        check_eq("txd_idle", {15'h0000, txd}, 16'h0001);
        read_status_check("tx_done_status");
        cpu_write(16'hBF00, 16'h00C3);
        tx_q.push_back(8'hC3);
        idle(200);
        check_eq("tx_frames_third", 16'(tx_frames), 16'd3);

        // Single RX frame
        send_frame(8'hA3, 1'b1);
        idle(2);
        read_status_check("rx_status_valid");
        read_data_check("rx_data_a3");
        read_status_check("rx_status_cleared");

        // Overrun then framing error, both cleared by a STATUS read
        send_frame(8'h11, 1'b1);
        idle(16);
        send_frame(8'h22, 1'b1);
        idle(2);
        read_data_check("rx_data_overrun");
        send_frame(8'h7E, 1'b0);
        idle(30);
        read_status_check("ovr_ferr_status");
        read_status_check("ovr_ferr_cleared");

        // Short low glitch is a false start
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        read_status_check("glitch_status");

        // Reset mid-frame discards the partial byte
        rxd = 1'b0;
        idle(16);
        rxd = 1'b1;
        idle(32);
        rst = 1'b1;
        #1 check_eq("rst_mid_txd", {15'h0000, txd}, 16'h0001);
        idle(3);
        rst = 1'b0;
        idle(200);
        read_status_check("rst_mid_status");

        // First frame after reset is received whole
        send_frame(8'h69, 1'b1);
        idle(2);
        read_status_check("post_rst_status");
        read_data_check("post_rst_data");

        check_eq("tx_queue_drained", 16'(tx_q.size()), 16'd0);
        check_eq("tx_frames_total", 16'(tx_frames), 16'd3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
